// File: rtl/fsm_share_sched.sv
// fsm_share_sched
//
// Shares one serial Moore detector among N_REQ requesters. A round-robin
// arbiter picks a requester and latches its W-bit word. The scheduler then
// pulses the detector's reset for one cycle and streams the word LSB-first
// into it. It counts the cycles in which the detector answers with j=1 and
// returns that count with a one-cycle done pulse.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   req      in   [N_REQ]    per-requester request level
//   data     in   [N_REQ*W]  requester k word at data[k*W +: W], sampled at grant
//   gnt      out  [N_REQ]    registered one-hot grant, held CLR..DONE
//   done     out             one-cycle completion pulse
//   result   out  [CW]       count of j-high samples, valid while done=1
//   fsm_rst  out             registered active-low reset to the shared detector
//   fsm_i    out             registered serial bit to the shared detector
//   fsm_j    in              detector Moore output
module fsm_share_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int CW    = $clog2(W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data,
    output logic [N_REQ-1:0]   gnt,
    output logic               done,
    output logic [CW-1:0]      result,
    output logic               fsm_rst,
    output logic               fsm_i,
    input  logic               fsm_j
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt_idx;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bitcnt;
    logic            smp;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [W-1:0]    pick_word;
    logic [CW-1:0]   cnt_inc;

    // Round-robin pick: the first requester at or after rr_ptr, searching
    // upward with wrap. The loop runs from the farthest offset down, so the
    // nearest candidate is written last and wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (req[(int'(rr_ptr) + off) % N_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = PW'((int'(rr_ptr) + off) % N_REQ);
            end
        end
        pick_word = data[int'(pick_idx) * W +: W];
    end

    // The count including this edge's sample. DRAIN uses it so that the
    // response to the last bit is already in result when done rises.
    assign cnt_inc = cnt + {{(CW - 1){1'b0}}, smp & fsm_j};

    // Scheduler FSM. All outputs are registered here. smp marks cycles in
    // which fsm_j reflects a bit that was driven in the previous cycle. That
    // gives exactly W samples, the last of which falls in DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= 1'b0;
            result  <= '0;
            fsm_rst <= 1'b0;
            fsm_i   <= 1'b0;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            shreg   <= '0;
            cnt     <= '0;
            bitcnt  <= '0;
            smp     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (smp) begin
                cnt <= cnt_inc;
            end
            case (state)
                IDLE: begin
                    fsm_rst <= 1'b1;
                    fsm_i   <= 1'b0;
                    gnt     <= '0;
                    smp     <= 1'b0;
                    if (pick_valid) begin
                        gnt     <= N_REQ'(1) << pick_idx;
                        gnt_idx <= pick_idx;
                        shreg   <= pick_word;
                        cnt     <= '0;
                        bitcnt  <= '0;
                        fsm_rst <= 1'b0;
                        state   <= CLR;
                    end
                end
                CLR: begin
                    fsm_rst <= 1'b1;
                    fsm_i   <= shreg[0];
                    shreg   <= shreg >> 1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    smp <= 1'b1;
                    if (bitcnt == BW'(W - 1)) begin
                        fsm_i <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        fsm_i  <= shreg[0];
                        shreg  <= shreg >> 1;
                        bitcnt <= bitcnt + BW'(1);
                    end
                end
                DRAIN: begin
                    smp    <= 1'b0;
                    result <= cnt_inc;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    result <= '0;
                    gnt    <= '0;
                    rr_ptr <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_share_sched.sv
// tb_fsm_share_sched
//
// Directed bench for fsm_share_sched with N_REQ=4 and W=8. It includes a
// stand-in detector whose j output is high after two or more consecutive 1s,
// and which is cleared by fsm_rst=0. Expected results are worked out by hand
// for each word.
module tb_fsm_share_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        done;
    logic [3:0]  result;
    logic        fsm_rst;
    logic        fsm_i;
    logic        fsm_j;

    int n_cmp = 0;
    int n_bad = 0;

    fsm_share_sched #(
        .N_REQ(4),
        .W    (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .fsm_rst(fsm_rst),
        .fsm_i  (fsm_i),
        .fsm_j  (fsm_j)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in detector: counts the run of 1s, saturating at 2.
    logic [1:0] run;
    always_ff @(posedge clk or negedge fsm_rst) begin
        if (!fsm_rst) begin
            run <= 2'd0;
        end else if (fsm_i) begin
            run <= (run == 2'd2) ? 2'd2 : run + 2'd1;
        end else begin
            run <= 2'd0;
        end
    end
    assign fsm_j = (run == 2'd2);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (gnt == 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        check_output({tag, "_gnt"}, 32'(gnt), 32'(exp));
    endtask

    // Called in cycle 'start' after the grant edge. Done must appear in
    // cycle 11 (W+3), then drop together with gnt one cycle later.
    task automatic wait_done(input string tag, input int start, input logic [3:0] exp_res);
        int n;
        n = start;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        check_output({tag, "_done_cycle"}, 32'(n), 32'd11);
        check_output({tag, "_result"}, 32'(result), 32'(exp_res));
        tick();
        check_output({tag, "_done_drop"}, 32'(done), 32'd0);
        check_output({tag, "_gnt_drop"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        logic [7:0] word;

        // Reset held with all requests active.
        rst  = 1'b0;
        req  = 4'b1111;
        data = 32'h0000_00FF;
        tick();
        tick();
        tick();
        check_output("rst_gnt", 32'(gnt), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_result", 32'(result), 32'd0);
        check_output("rst_fsm_rst", 32'(fsm_rst), 32'd0);
        check_output("rst_fsm_i", 32'(fsm_i), 32'd0);
        rst = 1'b1;
        tick();
        check_output("rel_gnt", 32'(gnt), 32'b0001);
        check_output("rel_clr", 32'(fsm_rst), 32'd0);
        req = 4'b0000;
        wait_done("rel", 1, 4'd7);

        // Single stream, requester 2, word 0x07. Checks every bit on fsm_i.
        req  = 4'b0100;
        data = 32'h0007_0000;
        word = 8'h07;
        tick();
        check_output("one_gnt", 32'(gnt), 32'b0100);
        check_output("one_clr", 32'({fsm_rst, fsm_i}), 32'b00);
        req = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_output($sformatf("one_bit%0d", k), 32'({fsm_rst, fsm_i}), 32'({1'b1, word[k]}));
        end
        tick();
        check_output("one_drain", 32'({done, fsm_i}), 32'b00);
        tick();
        check_output("one_done", 32'(done), 32'd1);
        check_output("one_result", 32'(result), 32'd2);
        tick();
        check_output("one_pulse", 32'(done), 32'd0);

        // Round robin: all four requesters held high after a fresh reset.
        rst = 1'b0;
        tick();
        rst  = 1'b1;
        req  = 4'b1111;
        data = 32'hAA33_00FF;
        wait_grant("rr0", 4'b0001);
        wait_done("rr0", 1, 4'd7);
        wait_grant("rr1", 4'b0010);
        wait_done("rr1", 1, 4'd0);
        wait_grant("rr2", 4'b0100);
        wait_done("rr2", 1, 4'd2);
        wait_grant("rr3", 4'b1000);
        wait_done("rr3", 1, 4'd0);
        wait_grant("rr4", 4'b0001);
        wait_done("rr4", 1, 4'd7);
        req = 4'b0000;

        // Abort in SHIFT cycle 4. The pointer is 1 here, so a grant to 0
        // afterwards shows that the pointer was reset.
        req  = 4'b0100;
        data = 32'h00FF_0000;
        wait_grant("ab", 4'b0100);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_output("ab_gnt", 32'(gnt), 32'd0);
        check_output("ab_fsm", 32'({fsm_rst, fsm_i}), 32'b00);
        req  = 4'b0101;
        data = 32'h00FF_0007;
        tick();
        tick();
        check_output("ab_nodone", 32'(done), 32'd0);
        check_output("ab_held", 32'({fsm_rst, fsm_j}), 32'b00);
        rst = 1'b1;
        wait_grant("ab_next", 4'b0001);
        wait_done("ab_next", 1, 4'd2);
        wait_grant("ab_after", 4'b0100);
        wait_done("ab_after", 1, 4'd7);
        req = 4'b0000;

        // Requester side: drop req and change data one cycle after grant.
        req  = 4'b0011;
        data = 32'h0000_0F33;
        wait_grant("rq", 4'b0001);
        tick();
        req  = 4'b0010;
        data = 32'h0000_0FFF;
        wait_done("rq", 2, 4'd2);
        wait_grant("rq_next", 4'b0010);
        wait_done("rq_next", 1, 4'd3);
        req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
